cache_data_bank: RTL and testbench

//  Parametrised multi-way cache data storage: SETS x WAYS lines of DATA_W bits.

---
 rtl/cache_data_bank_if.sv | 40 ++++
 rtl/cache_data_bank.sv | 88 ++++++++
 tb/tb_cache_data_bank.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_data_bank_if.sv
// cache_data_bank_if: write, read-request and read-response bundle
// for the multi-way cache data bank.
interface cache_data_bank_if #(
  parameter int DATA_W = 256,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
);
  localparam int IDX_W = SETS > 1 ? $clog2(SETS) : 1;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int BE_W  = DATA_W / 8;

  logic              init_busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_index;
  logic [WAY_W-1:0]  wr_way;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [IDX_W-1:0]  rd_index;
  logic [WAY_W-1:0]  rd_way;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  init_busy, wr_ready,
    input  rd_resp_valid, rd_data,
    output wr_valid, wr_index, wr_way,
    output wr_be, wr_data,
    output rd_valid, rd_index, rd_way
  );

  modport slave (
    output init_busy, wr_ready,
    output rd_resp_valid, rd_data,
    input  wr_valid, wr_index, wr_way,
    input  wr_be, wr_data,
    input  rd_valid, rd_index, rd_way
  );
endinterface

// File: rtl/cache_data_bank.sv
// cache_data_bank: SETS x WAYS byte-writable line store with a
// post-reset clear sweep and a 1-cycle write-first read port.
module cache_data_bank #(
  parameter int DATA_W = 256,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  cache_data_bank_if.slave bus
);
  localparam int IDX_W = SETS > 1 ? $clog2(SETS) : 1;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [SETS][WAYS];
  logic [DATA_W-1:0] mem_d [SETS][WAYS];
  logic              wr_ok;
  logic              rd_ok;

  assign bus.init_busy     = state_q == INIT;
  assign bus.wr_ready      = state_q == RUN;
  assign bus.rd_resp_valid = rd_vld_q;
  assign bus.rd_data       = rd_data_q;

  assign wr_ok = (int'(bus.wr_index) < SETS)
              && (int'(bus.wr_way) < WAYS);
  assign rd_ok = (int'(bus.rd_index) < SETS)
              && (int'(bus.rd_way) < WAYS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    rd_vld_d  = 1'b0;
    rd_data_d = rd_data_q;
    unique case (1'b1)
      state_q == INIT: begin
        for (int w = 0; w < WAYS; w++)
          mem_d[cnt_q][w] = '0;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      state_q == RUN: begin
        if (bus.wr_valid && wr_ok) begin
          for (int b = 0; b < BE_W; b++)
            if (bus.wr_be[b])
              mem_d[bus.wr_index][bus.wr_way][8*b +: 8] =
                bus.wr_data[8*b +: 8];
        end
        // mem_d already holds this cycle's write: write-first
        if (bus.rd_valid) begin
          rd_vld_d  = 1'b1;
          rd_data_d = '0;
          if (rd_ok)
            rd_data_d = mem_d[bus.rd_index][bus.rd_way];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
    end
  end
endmodule

// File: tb/tb_cache_data_bank.sv
// tb_cache_data_bank: directed checks of sweep, byte writes,
// forwarding, init blocking, mid-op reset and range handling.
module tb_cache_data_bank;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst8;
  logic rst6;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_data_bank_if #(.DATA_W(DW), .SETS(8), .WAYS(2)) b8();
  cache_data_bank_if #(.DATA_W(DW), .SETS(6), .WAYS(2)) b6();

  cache_data_bank #(.DATA_W(DW), .SETS(8), .WAYS(2)) dut8 (
    .clk(clk),
    .rst(rst8),
    .bus(b8)
  );

  cache_data_bank #(.DATA_W(DW), .SETS(6), .WAYS(2)) dut6 (
    .clk(clk),
    .rst(rst6),
    .bus(b6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    b8.wr_valid = 0; b8.rd_valid = 0;
    b8.wr_index = 0; b8.wr_way = 0;
    b8.wr_be = 0;    b8.wr_data = 0;
    b8.rd_index = 0; b8.rd_way = 0;
  endtask

  task automatic idle6();
    b6.wr_valid = 0; b6.rd_valid = 0;
    b6.wr_index = 0; b6.wr_way = 0;
    b6.wr_be = 0;    b6.wr_data = 0;
    b6.rd_index = 0; b6.rd_way = 0;
  endtask

  task automatic wr8(input int s, input int w,
                     input logic [31:0] be,
                     input logic [DW-1:0] d);
    b8.wr_valid = 1;
    b8.wr_index = 3'(s);
    b8.wr_way = 1'(w);
    b8.wr_be = be;
    b8.wr_data = d;
    step();
    b8.wr_valid = 0;
  endtask

  task automatic wr6(input int s, input int w,
                     input logic [31:0] be,
                     input logic [DW-1:0] d);
    b6.wr_valid = 1;
    b6.wr_index = 3'(s);
    b6.wr_way = 1'(w);
    b6.wr_be = be;
    b6.wr_data = d;
    step();
    b6.wr_valid = 0;
  endtask

  task automatic rd8(input int s, input int w,
                     output logic v,
                     output logic [DW-1:0] d);
    b8.rd_valid = 1;
    b8.rd_index = 3'(s);
    b8.rd_way = 1'(w);
    step();
    v = b8.rd_resp_valid;
    d = b8.rd_data;
    b8.rd_valid = 0;
  endtask

  task automatic rd6(input int s, input int w,
                     output logic v,
                     output logic [DW-1:0] d);
    b6.rd_valid = 1;
    b6.rd_index = 3'(s);
    b6.rd_way = 1'(w);
    step();
    v = b6.rd_resp_valid;
    d = b6.rd_data;
    b6.rd_valid = 0;
  endtask

  task automatic sweep8(output int n);
    n = 0;
    while (b8.init_busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic sweep6(output int n);
    n = 0;
    while (b6.init_busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst8 = 1;
    idle8();
    step(); step(); step();
    n_chk++;
    if (b8.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy: got %b exp 1", b8.init_busy);
    end
    n_chk++;
    if (b8.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got %b exp 0", b8.wr_ready);
    end
    n_chk++;
    if (b8.rd_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rvld: got %b exp 0", b8.rd_resp_valid);
    end
    n_chk++;
    if (b8.rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h exp 0", b8.rd_data);
    end
    rst8 = 0;
    sweep8(n);
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL sweep_len: got %0d exp 8", n);
    end
  endtask

  task automatic test_sweep();
    logic v;
    logic [DW-1:0] d;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        rd8(s, w, v, d);
        n_chk++;
        if (v !== 1'b1 || d !== '0) begin
          n_fail++;
          $display("FAIL sweep_rd s%0d w%0d: got v=%b d=%h exp v=1 d=0",
                   s, w, v, d);
        end
      end
  endtask

  task automatic test_byte_write();
    logic v;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    e = {224'b0, {4{8'hAA}}};
    wr8(3, 1, 32'h0000_000F, {32{8'hAA}});
    rd8(3, 1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== e) begin
      n_fail++;
      $display("FAIL bytewr: got v=%b d=%h exp v=1 d=%h", v, d, e);
    end
    rd8(3, 0, v, d);
    n_chk++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL bytewr_way0: got %h exp 0", d);
    end
  endtask

  task automatic test_forward();
    logic v;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    e = {32{8'h11}};
    e[7:0] = 8'h5C;
    e[255:248] = 8'h5C;
    wr8(5, 0, '1, {32{8'h11}});
    b8.wr_valid = 1; b8.wr_index = 3'd5; b8.wr_way = 1'b0;
    b8.wr_be = 32'h8000_0001; b8.wr_data = {32{8'h5C}};
    b8.rd_valid = 1; b8.rd_index = 3'd5; b8.rd_way = 1'b0;
    step();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b1 || b8.rd_data !== e) begin
      n_fail++;
      $display("FAIL fwd: got v=%b d=%h exp v=1 d=%h",
               b8.rd_resp_valid, b8.rd_data, e);
    end
    b8.rd_valid = 0;
    b8.wr_be = '1;
    b8.wr_data = '1;
    step();
    b8.wr_valid = 0;
    n_chk++;
    if (b8.rd_data !== e || b8.rd_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_hold: got v=%b d=%h exp v=0 d=%h",
               b8.rd_resp_valid, b8.rd_data, e);
    end
    rd8(5, 0, v, d);
    n_chk++;
    if (d !== '1) begin
      n_fail++;
      $display("FAIL fwd_after: got %h exp all ones", d);
    end
  endtask

  task automatic test_back_to_back();
    wr8(1, 0, '1, {32{8'hA1}});
    wr8(2, 1, '1, {32{8'hB2}});
    wr8(4, 0, '1, {32{8'hC4}});
    b8.rd_valid = 1; b8.rd_index = 3'd1; b8.rd_way = 1'b0;
    step();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b1 || b8.rd_data !== {32{8'hA1}}) begin
      n_fail++;
      $display("FAIL b2b_0: got v=%b d=%h exp A1s",
               b8.rd_resp_valid, b8.rd_data);
    end
    b8.rd_index = 3'd2; b8.rd_way = 1'b1;
    step();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b1 || b8.rd_data !== {32{8'hB2}}) begin
      n_fail++;
      $display("FAIL b2b_1: got v=%b d=%h exp B2s",
               b8.rd_resp_valid, b8.rd_data);
    end
    b8.rd_index = 3'd4; b8.rd_way = 1'b0;
    step();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b1 || b8.rd_data !== {32{8'hC4}}) begin
      n_fail++;
      $display("FAIL b2b_2: got v=%b d=%h exp C4s",
               b8.rd_resp_valid, b8.rd_data);
    end
    b8.rd_valid = 0;
    step();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b0 || b8.rd_data !== {32{8'hC4}}) begin
      n_fail++;
      $display("FAIL b2b_idle: got v=%b d=%h exp v=0 C4s",
               b8.rd_resp_valid, b8.rd_data);
    end
  endtask

  task automatic test_independent();
    logic v;
    logic [DW-1:0] d;
    b8.wr_valid = 1; b8.wr_index = 3'd6; b8.wr_way = 1'b1;
    b8.wr_be = '1; b8.wr_data = {32{8'h77}};
    b8.rd_valid = 1; b8.rd_index = 3'd1; b8.rd_way = 1'b0;
    step();
    idle8();
    n_chk++;
    if (b8.rd_data !== {32{8'hA1}}) begin
      n_fail++;
      $display("FAIL indep_rd: got %h exp A1s", b8.rd_data);
    end
    wr8(6, 1, 32'h0, '0);
    rd8(6, 1, v, d);
    n_chk++;
    if (d !== {32{8'h77}}) begin
      n_fail++;
      $display("FAIL indep_wr_be0: got %h exp 77s", d);
    end
  endtask

  task automatic test_init_block();
    int n;
    logic v;
    logic [DW-1:0] d;
    rst8 = 1;
    step();
    rst8 = 0;
    step(); step();
    b8.wr_valid = 1; b8.wr_index = 3'd3; b8.wr_way = 1'b1;
    b8.wr_be = '1; b8.wr_data = '1;
    b8.rd_valid = 1; b8.rd_index = 3'd3; b8.rd_way = 1'b1;
    n_chk++;
    if (b8.wr_ready !== 1'b0 || b8.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL init_ready: got rdy=%b busy=%b exp 0 1",
               b8.wr_ready, b8.init_busy);
    end
    step();
    idle8();
    n_chk++;
    if (b8.rd_resp_valid !== 1'b0 || b8.rd_data !== '0) begin
      n_fail++;
      $display("FAIL init_rd: got v=%b d=%h exp v=0 d=0",
               b8.rd_resp_valid, b8.rd_data);
    end
    sweep8(n);
    n_chk++;
    if (n !== 5) begin
      n_fail++;
      $display("FAIL init_rest: got %0d exp 5", n);
    end
    rd8(3, 1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL init_wr_drop: got v=%b d=%h exp v=1 d=0", v, d);
    end
    rd8(5, 0, v, d);
    n_chk++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL init_clear: got %h exp 0", d);
    end
  endtask

  task automatic test_midop_reset();
    int n;
    logic v;
    logic [DW-1:0] d;
    wr8(2, 0, '1, {32{8'h99}});
    wr8(7, 1, '1, {32{8'h33}});
    b8.rd_valid = 1; b8.rd_index = 3'd2; b8.rd_way = 1'b0;
    b8.wr_valid = 1; b8.wr_index = 3'd0; b8.wr_way = 1'b0;
    b8.wr_be = '1; b8.wr_data = {32{8'hEE}};
    rst8 = 1;
    step();
    idle8();
    rst8 = 0;
    n_chk++;
    if (b8.rd_resp_valid !== 1'b0 || b8.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_squash: got v=%b busy=%b exp 0 1",
               b8.rd_resp_valid, b8.init_busy);
    end
    sweep8(n);
    n_chk++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL mid_sweep: got %0d exp 8", n);
    end
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        rd8(s, w, v, d);
        n_chk++;
        if (v !== 1'b1 || d !== '0) begin
          n_fail++;
          $display("FAIL mid_rd s%0d w%0d: got v=%b d=%h exp v=1 d=0",
                   s, w, v, d);
        end
      end
  endtask

  task automatic test_range();
    int n;
    logic v;
    logic [DW-1:0] d;
    n_chk++;
    if (b6.init_busy !== 1'b1 || b6.rd_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rng_rst: got busy=%b v=%b exp 1 0",
               b6.init_busy, b6.rd_resp_valid);
    end
    rst6 = 0;
    sweep6(n);
    n_chk++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL rng_sweep: got %0d exp 6", n);
    end
    wr6(7, 0, '1, '1);
    wr6(6, 1, '1, '1);
    wr6(5, 1, '1, {32{8'h5A}});
    rd6(7, 0, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL rng_rd7: got v=%b d=%h exp v=1 d=0", v, d);
    end
    rd6(5, 1, v, d);
    n_chk++;
    if (v !== 1'b1 || d !== {32{8'h5A}}) begin
      n_fail++;
      $display("FAIL rng_last: got v=%b d=%h exp 5As", v, d);
    end
    for (int s = 0; s < 6; s++)
      for (int w = 0; w < 2; w++) begin
        if (s == 5 && w == 1) continue;
        rd6(s, w, v, d);
        n_chk++;
        if (v !== 1'b1 || d !== '0) begin
          n_fail++;
          $display("FAIL rng_rd s%0d w%0d: got v=%b d=%h exp 0",
                   s, w, v, d);
        end
      end
  endtask

  initial begin
    rst8 = 1;
    rst6 = 1;
    idle8();
    idle6();
    test_reset();
    test_sweep();
    test_byte_write();
    test_forward();
    test_back_to_back();
    test_independent();
    test_init_block();
    test_midop_reset();
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
